// File: rtl/rv_pkg.sv
// Shared RISC-V load/store encodings and the LSU bus-handshake state type.
package rv_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables/replication and load lane select/extension.
// The misaligned flag exists only when LSU_MISALIGN_TRAP_EN is defined.
module lsu_align
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            st_funct3,
  input  logic [1:0]            st_offset,
  input  logic [DATA_WIDTH-1:0] st_data,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] wdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic                  misaligned,
`endif
  input  logic [2:0]            ld_funct3,
  input  logic [1:0]            ld_offset,
  input  logic [DATA_WIDTH-1:0] ld_rdata,
  output logic [DATA_WIDTH-1:0] rdata_ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    be    = '1;
    wdata = st_data;
    case (st_funct3)
      F3_B, F3_BU: begin
        be = 4'b0001 << st_offset;
        for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) wdata[i*8 +: 8] = st_data[7:0];
      end
      F3_H, F3_HU: begin
        be = 4'b0011 << {st_offset[1], 1'b0};
        for (int unsigned i = 0; i < DATA_WIDTH / 16; i++) wdata[i*16 +: 16] = st_data[15:0];
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    case (st_funct3)
      F3_B, F3_BU: misaligned = 1'b0;
      F3_H, F3_HU: misaligned = st_offset[0];
      default:     misaligned = |st_offset;
    endcase
  end
`endif

  always_comb begin
    byte_lane = 8'(ld_rdata >> {ld_offset, 3'b000});
    half_lane = 16'(ld_rdata >> {ld_offset[1], 4'b0000});
    case (ld_funct3)
      F3_B:    rdata_ext = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
      F3_BU:   rdata_ext = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
      F3_H:    rdata_ext = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
      F3_HU:   rdata_ext = {{(DATA_WIDTH-16){1'b0}}, half_lane};
      default: rdata_ext = ld_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: stalls the pipeline while one bus transaction runs.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (adds MisalignM, suppresses misaligned H/W accesses).
module load_store_unit
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [ADDR_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_be,
  input  logic                  bus_gnt,
  input  logic                  bus_rvalid,
  input  logic [DATA_WIDTH-1:0] bus_rdata
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic                  MisalignM
`endif
);

  lsu_state_t            state_q, state_d;
  logic [2:0]            funct3_q;
  logic [1:0]            offset_q;
  logic [DATA_WIDTH-1:0] read_q;
  logic [3:0]            be_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [DATA_WIDTH-1:0] rdata_ext;
  logic                  access;
  logic                  start;

  assign access = MemReadM | MemWriteM;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  logic trap_q;
  assign start = (state_q == IDLE) & access & ~misaligned;
`else
  assign start = (state_q == IDLE) & access;
`endif

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .st_funct3  (Funct3M),
    .st_offset  (ALUResultM[1:0]),
    .st_data    (WriteDataM),
    .be         (be_next),
    .wdata      (wdata_next),
`ifdef LSU_MISALIGN_TRAP_EN
    .misaligned (misaligned),
`endif
    .ld_funct3  (funct3_q),
    .ld_offset  (offset_q),
    .ld_rdata   (bus_rdata),
    .rdata_ext  (rdata_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     if (bus_gnt) state_d = bus_we ? DONE : WAIT;
      WAIT:    if (bus_rvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A store presents zero only during its DONE cycle; read_q itself keeps the last load.
  always_comb begin
    bus_req   = (state_q == REQ);
    StallM    = start | (state_q == REQ) | (state_q == WAIT);
    ReadDataM = ((state_q == DONE) && bus_we) ? '0 : read_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_addr  <= '0;
      bus_we    <= 1'b0;
      bus_wdata <= '0;
      bus_be    <= '0;
      funct3_q  <= '0;
      offset_q  <= '0;
      read_q    <= '0;
    end else begin
      if (start) begin
        bus_addr  <= {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
        bus_we    <= MemWriteM;
        bus_wdata <= wdata_next;
        bus_be    <= be_next;
        funct3_q  <= Funct3M;
        offset_q  <= ALUResultM[1:0];
      end
      if ((state_q == WAIT) && bus_rvalid) read_q <= rdata_ext;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // trap_q limits the pulse to one cycle while the faulting access is still presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      trap_q <= 1'b0;
    else if (!access) trap_q <= 1'b0;
    else if (MisalignM) trap_q <= 1'b1;
  end

  always_comb MisalignM = (state_q == IDLE) & access & misaligned & ~trap_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit: bus-side expectations and load results queued at issue.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        StallM, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        MisalignM;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] read_q[$];

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .MisalignM  (MisalignM)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access from issue to DONE; the bench acts as the bus slave.
  task automatic do_access(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                           input int unsigned gnt_delay, input bus_exp_t eb,
                           input logic [31:0] exp_read, input int unsigned exp_stalls);
    int unsigned stalls = 0;
    int unsigned req_cycles = 0;
    int unsigned cycles = 0;
    logic granted = 1'b0;
    logic done = 1'b0;
    bus_exp_t cur;
    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wdata;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    bus_q.push_back(eb);
    read_q.push_back(exp_read);
    while (!done && cycles < 40) begin
      #1;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      if (!StallM) done = 1'b1;
      else begin
        stalls++;
        if (granted && !eb.we) begin
          bus_rvalid = 1'b1; bus_rdata = rdata; granted = 1'b0;
        end
        if (bus_req && bus_q.size() > 0) begin
          cur = bus_q[0];
          chk({name, "_addr"},  bus_addr, cur.addr);
          chk({name, "_be"},    32'(bus_be), 32'(cur.be));
          chk({name, "_wdata"}, bus_wdata, cur.wdata);
          chk({name, "_we"},    32'(bus_we), 32'(cur.we));
          if (req_cycles >= gnt_delay) begin
            bus_gnt = 1'b1; granted = 1'b1;
            void'(bus_q.pop_front());
          end
          req_cycles++;
        end
        @(negedge clk);
        cycles++;
      end
    end
    chk({name, "_completed"}, 32'(done), 32'd1);
    chk({name, "_read"}, ReadDataM, read_q.pop_front());
    chk({name, "_stalls"}, stalls, exp_stalls);
    chk({name, "_req_low_in_done"}, 32'(bus_req), 32'd0);
    MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  initial begin
    int unsigned n;
    logic seen;
    rst_n = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
    ALUResultM = '0; WriteDataM = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_stall", 32'(StallM), 32'd0);
    chk("rst_read", ReadDataM, 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    MemReadM = 1'b1;
    #1;
    chk("rst_stall_follows_access", 32'(StallM), 32'd1);
    MemReadM = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_access("lb", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF00, 0,
              '{32'h100, 4'b1000, 32'h0, 1'b0}, 32'hFFFF_FF80, 3);
    do_access("sh", 0, 1, 3'b001, 32'h102, 32'h0000_ABCD, 32'h0, 0,
              '{32'h100, 4'b1100, 32'hABCD_ABCD, 1'b1}, 32'h0, 2);
    @(negedge clk); #1;
    chk("hold_after_store", ReadDataM, 32'hFFFF_FF80);
    bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111;
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    chk("stray_rvalid_ignored", ReadDataM, 32'hFFFF_FF80);
    chk("stray_rvalid_no_stall", 32'(StallM), 32'd0);

    do_access("lw_slow", 1, 0, 3'b010, 32'h200, 32'h0, 32'h1234_5678, 4,
              '{32'h200, 4'b1111, 32'h0, 1'b0}, 32'h1234_5678, 7);
    do_access("sw_b2b", 0, 1, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h0, 0,
              '{32'h104, 4'b1111, 32'hDEAD_BEEF, 1'b1}, 32'h0, 2);
    do_access("lhu_b2b", 1, 0, 3'b101, 32'h102, 32'h0, 32'h8001_0000, 0,
              '{32'h100, 4'b1100, 32'h0, 1'b0}, 32'h0000_8001, 3);
    do_access("lh", 1, 0, 3'b001, 32'h100, 32'h0, 32'h0000_F00D, 0,
              '{32'h100, 4'b0011, 32'h0, 1'b0}, 32'hFFFF_F00D, 3);
    do_access("lbu", 1, 0, 3'b100, 32'h101, 32'h0, 32'h0000_AB00, 0,
              '{32'h100, 4'b0010, 32'h0, 1'b0}, 32'h0000_00AB, 3);
    do_access("sb", 0, 1, 3'b000, 32'h101, 32'h1234_565A, 32'h0, 0,
              '{32'h100, 4'b0010, 32'h5A5A_5A5A, 1'b1}, 32'h0, 2);
    do_access("unlisted_f3", 1, 0, 3'b011, 32'h10C, 32'h0, 32'hCAFE_F00D, 0,
              '{32'h10C, 4'b1111, 32'h0, 1'b0}, 32'hCAFE_F00D, 3);
    do_access("rd_wr_store", 1, 1, 3'b010, 32'h20, 32'h0BAD_F00D, 32'h5555_5555, 0,
              '{32'h20, 4'b1111, 32'h0BAD_F00D, 1'b1}, 32'h0, 2);
    @(negedge clk); #1;
    chk("hold_after_rdwr", ReadDataM, 32'hCAFE_F00D);

`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h101;
    #1;
    chk("mis_pulse", 32'(MisalignM), 32'd1);
    chk("mis_no_stall", 32'(StallM), 32'd0);
    chk("mis_no_req", 32'(bus_req), 32'd0);
    @(negedge clk); #1;
    chk("mis_pulse_end", 32'(MisalignM), 32'd0);
    chk("mis_no_req2", 32'(bus_req), 32'd0);
    chk("mis_no_stall2", 32'(StallM), 32'd0);
    MemReadM = 1'b0;
`else
    do_access("lh_mis", 1, 0, 3'b001, 32'h103, 32'h0, 32'hBEEF_0000, 0,
              '{32'h100, 4'b1100, 32'h0, 1'b0}, 32'hFFFF_BEEF, 3);
    do_access("lw_mis", 1, 0, 3'b010, 32'h102, 32'h0, 32'h0102_0304, 0,
              '{32'h100, 4'b1111, 32'h0, 1'b0}, 32'h0102_0304, 3);
`endif

    // Reset asserted while the load waits for read data.
    @(negedge clk);
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h300;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 10) begin
      #1;
      if (bus_req) begin
        seen = 1'b1;
        bus_gnt = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    chk("rst_wait_req_seen", 32'(seen), 32'd1);
    bus_gnt = 1'b0;
    #1;
    chk("rst_wait_stalled", 32'(StallM), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_wait_req", 32'(bus_req), 32'd0);
    chk("rst_wait_read", ReadDataM, 32'd0);
    chk("rst_wait_be", 32'(bus_be), 32'd0);
    chk("rst_wait_addr", bus_addr, 32'd0);
    chk("rst_wait_stall_access", 32'(StallM), 32'd1);
    bus_rvalid = 1'b1; bus_rdata = 32'h7777_7777;
    @(negedge clk);
    rst_n = 1'b1; MemReadM = 1'b0; bus_rvalid = 1'b0;
    #1;
    chk("post_rst_read", ReadDataM, 32'd0);
    chk("post_rst_stall", 32'(StallM), 32'd0);

    do_access("lb_recover", 1, 0, 3'b000, 32'h100, 32'h0, 32'h0000_007F, 0,
              '{32'h100, 4'b0001, 32'h0, 1'b0}, 32'h0000_007F, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
